exe_wb_slot_scheduler: RTL and testbench

- Writeback-slot scheduler for one execute pipe that holds a 1-cycle simple ALU and a DEPTH-cycle pipelined complex ALU.
- The two ALUs share a single writeback port.
- Sits between issue select and the execute pipe. It grants issue to simple or complex ops so their results never collide on the shared writeback port, and it drives the writeback mux select.
- Holds a per-slot reservation table, a starvation guard for simple ops, and squashes reservations on recovery.

---
 rtl/exe_wb_slot_scheduler.sv | 139 +++++++++++++
 tb/tb_exe_wb_slot_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_wb_slot_scheduler.sv
`timescale 1ns/1ps
// exe_wb_slot_scheduler
//   Writeback-slot scheduler for one execute pipe holding a 1-cycle simple ALU
//   and a DEPTH-cycle pipelined complex ALU that share one writeback port.
//   Grants issue so results never collide on the port and drives the
//   writeback mux select. Includes a starvation guard for simple ops and
//   squashes all reservations on recovery.
//
// Ports
//   clk               clock
//   reset             synchronous, active-high reset
//   recoverFlag_i     pipeline flush; squashes every in-flight reservation
//   simpleReq_i       a ready simple op wants to issue this cycle
//   complexReq_i      a ready complex op wants to issue this cycle
//   simpleGrant_o     simple op issues this cycle (combinational)
//   complexGrant_o    complex op issues this cycle (combinational)
//   wbSel_o           writeback source this cycle: 0 none, 1 simple, 2 complex
//   wbValid_o         wbSel_o != 0
//   complexInFlight_o complex results granted but not yet written back,
//                     counted through their writeback cycle
//   starve_o          starvation guard active (complex grants held off)
module exe_wb_slot_scheduler #(
    parameter int unsigned DEPTH        = 3,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       recoverFlag_i,
    input  logic       simpleReq_i,
    input  logic       complexReq_i,
    output logic       simpleGrant_o,
    output logic       complexGrant_o,
    output logic [1:0] wbSel_o,
    output logic       wbValid_o,
    output logic [3:0] complexInFlight_o,
    output logic       starve_o
);

    typedef enum logic [1:0] {
        SLOT_NONE    = 2'd0,
        SLOT_SIMPLE  = 2'd1,
        SLOT_COMPLEX = 2'd2
    } slot_e;

    localparam logic SINGLE_STAGE = (DEPTH == 1);

    // slot_q[k] is the writeback occupant k cycles from now; slot_q[0] is the
    // current writeback. slot_q[DEPTH] is never loaded, so it always reads
    // NONE: a complex grant lands in slot DEPTH-1 (the shifted-in free slot)
    // and needs no collision check, while a simple grant lands in slot 0 and
    // only has to check slot 1.
    slot_e      slot_q [0:DEPTH];
    slot_e      slot_d [0:DEPTH];
    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;
    logic       starve_q;
    logic       starve_d;
    logic       simple_grant;
    logic       complex_grant;
    logic [3:0] inflight;

    always_comb begin
        complex_grant = complexReq_i & ~starve_q & ~recoverFlag_i & ~reset;
        simple_grant  = simpleReq_i & (slot_q[1] == SLOT_NONE)
                      & ~(SINGLE_STAGE & complex_grant)
                      & ~recoverFlag_i & ~reset;
    end

    always_comb begin
        for (int unsigned k = 0; k <= DEPTH; k++) begin
            slot_d[k] = SLOT_NONE;
        end
        if (!recoverFlag_i) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                slot_d[k] = slot_q[k + 1];
            end
            if (complex_grant) begin
                slot_d[DEPTH - 1] = SLOT_COMPLEX;
            end
            if (simple_grant) begin
                slot_d[0] = SLOT_SIMPLE;
            end
        end
    end

    // Starve follows the saturating denial count, so it drops the cycle after
    // a simple grant or a dropped request, and on recovery.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!simpleReq_i || simple_grant || recoverFlag_i) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != 4'hF) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
        starve_d = (starve_cnt_d >= 4'(STARVE_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k <= DEPTH; k++) begin
                slot_q[k] <= SLOT_NONE;
            end
            starve_cnt_q <= '0;
            starve_q     <= 1'b0;
        end else begin
            for (int unsigned k = 0; k <= DEPTH; k++) begin
                slot_q[k] <= slot_d[k];
            end
            starve_cnt_q <= starve_cnt_d;
            starve_q     <= starve_d;
        end
    end

    always_comb begin
        inflight = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (slot_q[k] == SLOT_COMPLEX) begin
                inflight = inflight + 4'd1;
            end
        end
    end

    always_comb begin
        simpleGrant_o  = simple_grant;
        complexGrant_o = complex_grant;
        if (reset) begin
            wbSel_o           = '0;
            wbValid_o         = 1'b0;
            complexInFlight_o = '0;
            starve_o          = 1'b0;
        end else begin
            wbSel_o           = slot_q[0];
            wbValid_o         = (slot_q[0] != SLOT_NONE);
            complexInFlight_o = inflight;
            starve_o          = starve_q;
        end
    end

endmodule

// File: tb/tb_exe_wb_slot_scheduler.sv
`timescale 1ns/1ps
module tb_exe_wb_slot_scheduler;

    localparam int SG  = 0;
    localparam int CG  = 1;
    localparam int WS  = 2;
    localparam int WV  = 3;
    localparam int CIF = 4;
    localparam int ST  = 5;
    localparam int M3  = 0;   // DEPTH=3 instance
    localparam int M1  = 1;   // DEPTH=1 instance

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset         = 1'b1;
    logic recoverFlag_i = 1'b0;
    logic simpleReq_i   = 1'b0;
    logic complexReq_i  = 1'b0;

    logic       sg3, cg3, wv3, st3;
    logic [1:0] ws3;
    logic [3:0] cif3;
    logic       sg1, cg1, wv1, st1;
    logic [1:0] ws1;
    logic [3:0] cif1;

    exe_wb_slot_scheduler #(.DEPTH(3), .STARVE_LIMIT(4)) u_d3 (
        .clk(clk), .reset(reset), .recoverFlag_i(recoverFlag_i),
        .simpleReq_i(simpleReq_i), .complexReq_i(complexReq_i),
        .simpleGrant_o(sg3), .complexGrant_o(cg3), .wbSel_o(ws3),
        .wbValid_o(wv3), .complexInFlight_o(cif3), .starve_o(st3)
    );

    exe_wb_slot_scheduler #(.DEPTH(1), .STARVE_LIMIT(4)) u_d1 (
        .clk(clk), .reset(reset), .recoverFlag_i(recoverFlag_i),
        .simpleReq_i(simpleReq_i), .complexReq_i(complexReq_i),
        .simpleGrant_o(sg1), .complexGrant_o(cg1), .wbSel_o(ws1),
        .wbValid_o(wv1), .complexInFlight_o(cif1), .starve_o(st1)
    );

    int n_pass  = 0;
    int n_total = 0;
    int mcyc    = 0;

    // Calendar model: book[m][c] is the writeback source booked for absolute cycle c.
    int book [0:1][0:2047] = '{default: 0};
    int scnt [0:1] = '{default: 0};
    int mstarve [0:1] = '{default: 0};

    typedef struct {
        string name;
        int    m;
        int    k;
        int    exp;
    } lit_t;
    lit_t lit_q[$];

    function automatic int get_sig(int m, int k);
        int v;
        v = 0;
        if (m == M3) begin
            case (k)
                SG:      v = int'(sg3);
                CG:      v = int'(cg3);
                WS:      v = int'(ws3);
                WV:      v = int'(wv3);
                CIF:     v = int'(cif3);
                default: v = int'(st3);
            endcase
        end else begin
            case (k)
                SG:      v = int'(sg1);
                CG:      v = int'(cg1);
                WS:      v = int'(ws1);
                WV:      v = int'(wv1);
                CIF:     v = int'(cif1);
                default: v = int'(st1);
            endcase
        end
        return v;
    endfunction

    function automatic string sig_name(int k);
        string s;
        case (k)
            SG:      s = "simpleGrant";
            CG:      s = "complexGrant";
            WS:      s = "wbSel";
            WV:      s = "wbValid";
            CIF:     s = "complexInFlight";
            default: s = "starve";
        endcase
        return s;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0d expected %0d", name, mcyc, act, exp);
    endtask

    always @(negedge clk) begin : compare
        int   d;
        int   cg_m;
        int   sg_m;
        int   inflight;
        int   exp_v [0:5];
        lit_t lit;
        if (mcyc < 2000) begin
            for (int m = 0; m < 2; m++) begin
                d = (m == M3) ? 3 : 1;
                cg_m = (complexReq_i && mstarve[m] == 0 && !recoverFlag_i && !reset) ? 1 : 0;
                sg_m = (simpleReq_i && book[m][mcyc + 1] == 0 && !(d == 1 && cg_m == 1)
                        && !recoverFlag_i && !reset) ? 1 : 0;
                inflight = 0;
                for (int j = 0; j < d; j++) begin
                    if (book[m][mcyc + j] == 2) inflight++;
                end
                exp_v[SG]  = sg_m;
                exp_v[CG]  = cg_m;
                exp_v[WS]  = reset ? 0 : book[m][mcyc];
                exp_v[WV]  = (exp_v[WS] != 0) ? 1 : 0;
                exp_v[CIF] = reset ? 0 : inflight;
                exp_v[ST]  = reset ? 0 : mstarve[m];
                for (int k = 0; k < 6; k++) begin
                    chk($sformatf("d%0d.%s", d, sig_name(k)), get_sig(m, k), exp_v[k]);
                end
                if (reset || recoverFlag_i) begin
                    for (int c = 1; c <= 8; c++) book[m][mcyc + c] = 0;
                end else begin
                    if (cg_m == 1) book[m][mcyc + d] = 2;
                    if (sg_m == 1) book[m][mcyc + 1] = 1;
                end
                if (reset || recoverFlag_i || !simpleReq_i || sg_m == 1) scnt[m] = 0;
                else if (scnt[m] < 15) scnt[m]++;
                mstarve[m] = (scnt[m] >= 4) ? 1 : 0;
            end
            while (lit_q.size() > 0) begin
                lit = lit_q.pop_front();
                chk(lit.name, get_sig(lit.m, lit.k), lit.exp);
            end
            mcyc++;
        end
    end

    task automatic step(input logic r, input logic rc, input logic s, input logic c);
        @(posedge clk);
        #1;
        reset         = r;
        recoverFlag_i = rc;
        simpleReq_i   = s;
        complexReq_i  = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic lit(input string nm, input int m, input int k, input int e);
        lit_t l;
        l.name = nm;
        l.m    = m;
        l.k    = k;
        l.exp  = e;
        lit_q.push_back(l);
    endtask

    initial begin
        // reset and post-reset state
        step(1'b1, 1'b0, 1'b1, 1'b1);
        lit("rst.cg", M3, CG, 0);
        lit("rst.sg", M3, SG, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        lit("post_rst.ws", M3, WS, 0);
        lit("post_rst.cif", M3, CIF, 0);
        lit("post_rst.st", M3, ST, 0);
        idle(1);

        // 1: single complex op, DEPTH=3
        step(1'b0, 1'b0, 1'b0, 1'b1);
        lit("t1.c0.cg", M3, CG, 1);
        lit("t1.c0.ws", M3, WS, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        lit("t1.c1.cif", M3, CIF, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        lit("t1.c2.cif", M3, CIF, 1);
        lit("t1.c2.ws", M3, WS, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        lit("t1.c3.ws", M3, WS, 2);
        lit("t1.c3.cif", M3, CIF, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        lit("t1.c4.ws", M3, WS, 0);
        lit("t1.c4.cif", M3, CIF, 0);
        idle(2);

        // 2: simple blocked by a complex writeback in the next slot
        step(1'b0, 1'b0, 1'b0, 1'b1);
        lit("t2.c0.cg", M3, CG, 1);
        idle(1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        lit("t2.c2.sg", M3, SG, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        lit("t2.c3.sg", M3, SG, 1);
        lit("t2.c3.ws", M3, WS, 2);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        lit("t2.c4.ws", M3, WS, 1);
        idle(3);

        // 3: starvation guard, both requests held
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            case (c)
                0: begin lit("t3.c0.sg", M3, SG, 1); lit("t3.c0.cg", M3, CG, 1); end
                1: lit("t3.c1.sg", M3, SG, 1);
                2, 3, 4, 5: begin
                    lit($sformatf("t3.c%0d.sg", c), M3, SG, 0);
                    lit($sformatf("t3.c%0d.cg", c), M3, CG, 1);
                    lit($sformatf("t3.c%0d.st", c), M3, ST, 0);
                end
                6: begin
                    lit("t3.c6.st", M3, ST, 1);
                    lit("t3.c6.cg", M3, CG, 0);
                    lit("t3.c6.sg", M3, SG, 0);
                end
                7: begin lit("t3.c7.sg", M3, SG, 0); lit("t3.c7.cg", M3, CG, 0); end
                8: begin
                    lit("t3.c8.sg", M3, SG, 1);
                    lit("t3.c8.st", M3, ST, 1);
                    lit("t3.c8.cg", M3, CG, 0);
                end
                default: begin lit("t3.c9.st", M3, ST, 0); lit("t3.c9.cg", M3, CG, 1); end
            endcase
        end
        idle(5);

        // 4: DEPTH=1 contention, complex wins
        step(1'b0, 1'b0, 1'b1, 1'b1);
        lit("t4.c0.d1.cg", M1, CG, 1);
        lit("t4.c0.d1.sg", M1, SG, 0);
        lit("t4.c0.d3.sg", M3, SG, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        lit("t4.c1.d1.ws", M1, WS, 2);
        lit("t4.c1.d1.cif", M1, CIF, 1);
        lit("t4.c1.d3.ws", M3, WS, 1);
        idle(4);

        // 5: recovery squashes in-flight complex ops
        step(1'b0, 1'b0, 1'b0, 1'b1);
        lit("t5.c0.cg", M3, CG, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        lit("t5.c1.cg", M3, CG, 1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        lit("t5.c2.cg", M3, CG, 0);
        lit("t5.c2.sg", M3, SG, 0);
        lit("t5.c2.cif", M3, CIF, 2);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        lit("t5.c3.ws", M3, WS, 0);
        lit("t5.c3.wv", M3, WV, 0);
        lit("t5.c3.cif", M3, CIF, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        lit("t5.c4.ws", M3, WS, 0);
        idle(3);

        // 6: reset with ops in flight
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        lit("t6.c5.cg", M3, CG, 0);
        lit("t6.c5.sg", M3, SG, 0);
        lit("t6.c5.d1.cg", M1, CG, 0);
        lit("t6.c5.ws", M3, WS, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        lit("t6.c6.ws", M3, WS, 0);
        lit("t6.c6.wv", M3, WV, 0);
        lit("t6.c6.cif", M3, CIF, 0);
        lit("t6.c6.st", M3, ST, 0);
        lit("t6.c6.cg", M3, CG, 1);
        lit("t6.c6.d1.ws", M1, WS, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        lit("t6.c7.ws", M3, WS, 0);
        lit("t6.c7.wv", M3, WV, 0);
        lit("t6.c7.d1.ws", M1, WS, 2);
        idle(1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        lit("t6.c9.ws", M3, WS, 2);
        idle(2);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
